// File: rtl/knob_value.sv
// knob_value
//   Tracks a front-panel parameter driven by a quadrature detent counter.
//   The free-running 8-bit counter is sampled every SAMPLE_DIV clocks. The
//   wrap-around difference becomes a signed delta. That delta is applied,
//   with acceleration, to a value saturated to [MIN, MAX]. Each delta is
//   also reported on a valid/ready event port, which merges deltas while
//   the host stalls.
//
// Ports
//   clk         in   clock, all logic on posedge
//   reset       in   synchronous, active-high reset
//   counter     in   [7:0]       detent count from the decoder (wraps mod 256)
//   load        in               one-cycle strobe, loads load_value
//   load_value  in   [WIDTH-1:0] value to load, clamped to [MIN, MAX]
//   value       out  [WIDTH-1:0] current parameter value
//   changed     out              one-cycle pulse whenever value changes
//   evt_valid   out              event pending
//   evt_ready   in               host accepts the event when high with evt_valid
//   evt_delta   out  [7:0]       signed accumulated delta of the pending event
//   evt_sat     out              pending delta was clipped while merging
module knob_value #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned MIN         = 0,
  parameter int unsigned MAX         = 1000,
  parameter int unsigned STEP        = 1,
  parameter int unsigned FAST_STEP   = 10,
  parameter int unsigned FAST_THRESH = 3,
  parameter int unsigned SAMPLE_DIV  = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       counter,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             changed,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_delta,
  output logic             evt_sat
);

  localparam int unsigned MAXSTEP = (FAST_STEP > STEP) ? FAST_STEP : STEP;
  // Candidate width: value + sign/guard + 8-bit delta + step magnitude.
  localparam int unsigned CW = WIDTH + 2 + 8 + $clog2(MAXSTEP + 1);
  localparam int unsigned PW = $clog2(SAMPLE_DIV);

  localparam logic [WIDTH-1:0]     MIN_W = WIDTH'(MIN);
  localparam logic [WIDTH-1:0]     MAX_W = WIDTH'(MAX);
  localparam logic signed [CW-1:0] MIN_S = CW'(MIN);
  localparam logic signed [CW-1:0] MAX_S = CW'(MAX);

  // Stage 1: prescaler and counter sampling
  logic [PW-1:0]      prescaler;
  logic               tick;
  logic [7:0]         last_count;
  logic               primed;
  logic [7:0]         raw_delta;

  // Stage 2: delta application
  logic               s2_valid;
  logic signed [7:0]  s2_delta;

  logic [7:0]         abs_delta;
  logic               fast;
  logic signed [CW-1:0] value_s;
  logic signed [CW-1:0] delta_s;
  logic signed [CW-1:0] step_s;
  logic signed [CW-1:0] cand;
  logic [WIDTH-1:0]   step_value;
  logic [WIDTH-1:0]   load_clamped;
  logic [WIDTH-1:0]   next_value;
  logic signed [8:0]  merged;

  assign tick = (prescaler == PW'(SAMPLE_DIV - 1));

  always_comb begin
    raw_delta = counter - last_count;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler  <= '0;
      last_count <= '0;
      primed     <= 1'b0;
      s2_valid   <= 1'b0;
      s2_delta   <= '0;
    end else begin
      s2_valid <= 1'b0;
      if (tick) begin
        prescaler  <= '0;
        last_count <= counter;
        primed     <= 1'b1;
        // The first sample after reset only establishes the reference count.
        if (primed && (raw_delta != 8'd0)) begin
          s2_valid <= 1'b1;
          s2_delta <= $signed(raw_delta);
        end
      end else begin
        prescaler <= prescaler + PW'(1);
      end
    end
  end

  always_comb begin
    abs_delta = s2_delta[7] ? 8'(-s2_delta) : 8'(s2_delta);
    fast      = (32'(abs_delta) >= FAST_THRESH);
    step_s    = fast ? CW'(FAST_STEP) : CW'(STEP);
    value_s   = CW'(value);
    delta_s   = CW'(s2_delta);
    cand      = value_s + delta_s * step_s;

    if (cand < MIN_S)      step_value = MIN_W;
    else if (cand > MAX_S) step_value = MAX_W;
    else                   step_value = cand[WIDTH-1:0];

    if (load_value < MIN_W)      load_clamped = MIN_W;
    else if (load_value > MAX_W) load_clamped = MAX_W;
    else                         load_clamped = load_value;

    // A load in the stage-2 cycle takes priority; that delta is only reported.
    if (load)          next_value = load_clamped;
    else if (s2_valid) next_value = step_value;
    else               next_value = value;

    merged = $signed({evt_delta[7], evt_delta}) + $signed({s2_delta[7], s2_delta});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value   <= MIN_W;
      changed <= 1'b0;
    end else begin
      value   <= next_value;
      changed <= (next_value != value);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      evt_valid <= 1'b0;
      evt_delta <= '0;
      evt_sat   <= 1'b0;
    end else if (s2_valid) begin
      if (!evt_valid || evt_ready) begin
        evt_valid <= 1'b1;
        evt_delta <= s2_delta;
        evt_sat   <= 1'b0;
      end else if (merged > 9'sd127) begin
        evt_delta <= 8'h7f;
        evt_sat   <= 1'b1;
      end else if (merged < -9'sd128) begin
        evt_delta <= 8'h80;
        evt_sat   <= 1'b1;
      end else begin
        evt_delta <= merged[7:0];
      end
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_knob_value.sv
module tb_knob_value;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  counter = '0;
  logic        load = 1'b0;
  logic [15:0] load_value = '0;
  logic        evt_ready = 1'b0;
  logic [15:0] value;
  logic        changed;
  logic        evt_valid;
  logic [7:0]  evt_delta;
  logic        evt_sat;

  knob_value #(
    .WIDTH(16), .MIN(0), .MAX(1000), .STEP(1), .FAST_STEP(10),
    .FAST_THRESH(3), .SAMPLE_DIV(SD)
  ) dut (
    .clk(clk), .reset(reset), .counter(counter), .load(load),
    .load_value(load_value), .value(value), .changed(changed),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_delta(evt_delta),
    .evt_sat(evt_sat)
  );

  always #5 clk = ~clk;

  // Independent phase model of the sample prescaler.
  int unsigned tb_pre = 0;
  always @(posedge clk) begin
    if (reset) tb_pre <= 0;
    else       tb_pre <= (tb_pre == SD - 1) ? 0 : tb_pre + 1;
  end

  typedef struct {
    int value;
    bit changed;
    bit ev;
    int ed;
    bit sat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  int         m_value = 0;
  logic [7:0] m_last = '0;
  bit         m_primed = 0;
  bit         m_ev = 0;
  int         m_ed = 0;
  bit         m_sat = 0;

  function automatic int clampv(input int x);
    return (x < 0) ? 0 : ((x > 1000) ? 1000 : x);
  endfunction

  task automatic model_reset();
    m_value = 0; m_last = '0; m_primed = 0; m_ev = 0; m_ed = 0; m_sat = 0;
  endtask

  task automatic idle_cycle();
    if (m_ev && evt_ready) m_ev = 0;
    @(posedge clk); #1;
  endtask

  // kind 0: sample counter=arg; kind 1: load-only of arg; kind 2: sample with load of lv
  task automatic drive(input int kind, input int arg, input int lv);
    int         d = 0;
    int         nv;
    int         guard = 0;
    logic [7:0] diff;
    exp_t       e;
    if (kind != 1) begin
      counter = 8'(arg);
      while (tb_pre != SD - 1 && guard < 2 * SD) begin
        idle_cycle();
        guard++;
      end
      if (tb_pre != SD - 1) begin
        n_cmp++; n_err++;
        $display("FAIL align: prescaler phase %0d, required %0d", tb_pre, SD - 1);
      end
      idle_cycle();  // tick edge
      if (m_primed) begin
        diff = counter - m_last;
        d = int'($signed(diff));
      end
      m_primed = 1;
      m_last = counter;
    end
    if (kind != 0) begin
      load = 1'b1;
      load_value = 16'((kind == 1) ? arg : lv);
    end
    if (kind != 0)   nv = clampv(int'(load_value));
    else if (d != 0) nv = clampv(m_value + d * ((d >= 3 || d <= -3) ? 10 : 1));
    else             nv = m_value;
    e.changed = (nv != m_value);
    m_value = nv;
    if (d != 0) begin
      if (!m_ev || evt_ready) begin
        m_ev = 1; m_ed = d; m_sat = 0;
      end else begin
        m_ed = m_ed + d;
        if (m_ed > 127) begin m_ed = 127; m_sat = 1; end
        else if (m_ed < -128) begin m_ed = -128; m_sat = 1; end
      end
    end else if (m_ev && evt_ready) begin
      m_ev = 0;
    end
    e.value = nv; e.ev = m_ev; e.ed = m_ed; e.sat = m_sat;
    sb.push_back(e);
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (value !== 16'd0) begin n_err++; $display("FAIL reset value: got %0d want 0", value); end
    n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL reset changed: got %b want 0", changed); end
    n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL reset evt_valid: got %b want 0", evt_valid); end
    n_cmp++; if (evt_delta !== 8'd0) begin n_err++; $display("FAIL reset evt_delta: got %0d want 0", evt_delta); end
    n_cmp++; if (evt_sat !== 1'b0) begin n_err++; $display("FAIL reset evt_sat: got %b want 0", evt_sat); end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0);
      e = sb.pop_front();
      n_cmp++; if (value !== 16'(e.value)) begin n_err++; $display("FAIL prime value: got %0d want %0d", value, e.value); end
      n_cmp++; if (changed !== e.changed) begin n_err++; $display("FAIL prime changed: got %b want %b", changed, e.changed); end
      n_cmp++; if (evt_valid !== e.ev) begin n_err++; $display("FAIL prime evt_valid: got %b want %b", evt_valid, e.ev); end
    end
  endtask

  task automatic test_basic();
    exp_t e;
    evt_ready = 1'b1;
    drive(0, 2, 0);
    e = sb.pop_front();
    n_cmp++; if (value !== 16'(e.value)) begin n_err++; $display("FAIL basic value: got %0d want %0d", value, e.value); end
    n_cmp++; if (changed !== e.changed) begin n_err++; $display("FAIL basic changed: got %b want %b", changed, e.changed); end
    n_cmp++; if (evt_valid !== e.ev) begin n_err++; $display("FAIL basic evt_valid: got %b want %b", evt_valid, e.ev); end
    n_cmp++; if (evt_delta !== 8'(e.ed)) begin n_err++; $display("FAIL basic evt_delta: got %0d want %0d", $signed(evt_delta), e.ed); end
    idle_cycle();
    n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL basic changed_pulse: got %b want 0", changed); end
    n_cmp++; if (evt_valid !== m_ev) begin n_err++; $display("FAIL basic evt_drop: got %b want %b", evt_valid, m_ev); end
  endtask

  // Steps shared by the scenario tests: kinds/args tables driven then checked inline.
  task automatic test_wrap();
    int   cnts[3] = '{250, 5, 250};
    exp_t e;
    evt_ready = 1'b1;
    foreach (cnts[i]) begin
      drive(0, cnts[i], 0);
      e = sb.pop_front();
      n_cmp++; if (value !== 16'(e.value)) begin n_err++; $display("FAIL wrap[%0d] value: got %0d want %0d", i, value, e.value); end
      n_cmp++; if (changed !== e.changed) begin n_err++; $display("FAIL wrap[%0d] changed: got %b want %b", i, changed, e.changed); end
      n_cmp++; if (evt_valid !== e.ev) begin n_err++; $display("FAIL wrap[%0d] evt_valid: got %b want %b", i, evt_valid, e.ev); end
      if (e.ev) begin
        n_cmp++; if (evt_delta !== 8'(e.ed)) begin n_err++; $display("FAIL wrap[%0d] evt_delta: got %0d want %0d", i, $signed(evt_delta), e.ed); end
      end
    end
  endtask

  task automatic test_max();
    int   kinds[3] = '{1, 0, 0};
    int   args[3]  = '{995, 253, 254};
    exp_t e;
    evt_ready = 1'b1;
    foreach (kinds[i]) begin
      drive(kinds[i], args[i], 0);
      e = sb.pop_front();
      n_cmp++; if (value !== 16'(e.value)) begin n_err++; $display("FAIL max[%0d] value: got %0d want %0d", i, value, e.value); end
      n_cmp++; if (changed !== e.changed) begin n_err++; $display("FAIL max[%0d] changed: got %b want %b", i, changed, e.changed); end
      n_cmp++; if (evt_valid !== e.ev) begin n_err++; $display("FAIL max[%0d] evt_valid: got %b want %b", i, evt_valid, e.ev); end
      if (e.ev) begin
        n_cmp++; if (evt_delta !== 8'(e.ed)) begin n_err++; $display("FAIL max[%0d] evt_delta: got %0d want %0d", i, $signed(evt_delta), e.ed); end
      end
    end
  endtask

  task automatic test_merge();
    int   cnts[3] = '{98, 198, 199};
    exp_t e;
    evt_ready = 1'b1;
    idle_cycle();
    evt_ready = 1'b0;
    foreach (cnts[i]) begin
      if (i == 2) begin
        evt_ready = 1'b1;
        idle_cycle();
        n_cmp++; if (evt_valid !== m_ev) begin n_err++; $display("FAIL merge accept evt_valid: got %b want %b", evt_valid, m_ev); end
      end
      drive(0, cnts[i], 0);
      e = sb.pop_front();
      n_cmp++; if (value !== 16'(e.value)) begin n_err++; $display("FAIL merge[%0d] value: got %0d want %0d", i, value, e.value); end
      n_cmp++; if (changed !== e.changed) begin n_err++; $display("FAIL merge[%0d] changed: got %b want %b", i, changed, e.changed); end
      n_cmp++; if (evt_valid !== e.ev) begin n_err++; $display("FAIL merge[%0d] evt_valid: got %b want %b", i, evt_valid, e.ev); end
      n_cmp++; if (evt_delta !== 8'(e.ed)) begin n_err++; $display("FAIL merge[%0d] evt_delta: got %0d want %0d", i, $signed(evt_delta), e.ed); end
      n_cmp++; if (evt_sat !== e.sat) begin n_err++; $display("FAIL merge[%0d] evt_sat: got %b want %b", i, evt_sat, e.sat); end
    end
  endtask

  task automatic test_collision();
    int   kinds[3] = '{1, 1, 2};
    int   args[3]  = '{5000, 500, 200};
    exp_t e;
    evt_ready = 1'b1;
    foreach (kinds[i]) begin
      drive(kinds[i], args[i], 5000);
      e = sb.pop_front();
      n_cmp++; if (value !== 16'(e.value)) begin n_err++; $display("FAIL collide[%0d] value: got %0d want %0d", i, value, e.value); end
      n_cmp++; if (changed !== e.changed) begin n_err++; $display("FAIL collide[%0d] changed: got %b want %b", i, changed, e.changed); end
      n_cmp++; if (evt_valid !== e.ev) begin n_err++; $display("FAIL collide[%0d] evt_valid: got %b want %b", i, evt_valid, e.ev); end
      if (e.ev) begin
        n_cmp++; if (evt_delta !== 8'(e.ed)) begin n_err++; $display("FAIL collide[%0d] evt_delta: got %0d want %0d", i, $signed(evt_delta), e.ed); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int   cnts[3] = '{201, 77, 80};
    exp_t e;
    evt_ready = 1'b0;
    foreach (cnts[i]) begin
      if (i == 1) begin
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL midreset evt_valid: got %b want 0", evt_valid); end
        n_cmp++; if (value !== 16'd0) begin n_err++; $display("FAIL midreset value: got %0d want 0", value); end
        reset = 1'b0;
      end
      drive(0, cnts[i], 0);
      e = sb.pop_front();
      n_cmp++; if (value !== 16'(e.value)) begin n_err++; $display("FAIL rst[%0d] value: got %0d want %0d", i, value, e.value); end
      n_cmp++; if (changed !== e.changed) begin n_err++; $display("FAIL rst[%0d] changed: got %b want %b", i, changed, e.changed); end
      n_cmp++; if (evt_valid !== e.ev) begin n_err++; $display("FAIL rst[%0d] evt_valid: got %b want %b", i, evt_valid, e.ev); end
      if (e.ev) begin
        n_cmp++; if (evt_delta !== 8'(e.ed)) begin n_err++; $display("FAIL rst[%0d] evt_delta: got %0d want %0d", i, $signed(evt_delta), e.ed); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_max();
    test_merge();
    test_collision();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
